// File: rtl/y86_pkg.sv
// Shared types and constants for the Y86 bus/memory block.
package y86_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [31:0] CON_ADDR_DEF = 32'hFFFF_FF00;
  localparam int          CNT_W        = 16;

endpackage

// File: rtl/y86_sat_counter.sv
// Saturating up-counter with synchronous clear.
module y86_sat_counter
  import y86_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/y86_bus_mem.sv
// Byte-addressed memory for a Y86 CPU: boot-time byte loader, 32-bit LE bus, console port.
module y86_bus_mem
  import y86_pkg::*;
#(
  parameter int          DEPTH    = 1024,
  parameter logic [31:0] CON_ADDR = CON_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       bus_A,
  input  logic [31:0]       bus_out,
  input  logic              bus_WE,
  input  logic              bus_RE,
  output logic [31:0]       bus_in,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              cpu_rst,
  output logic              con_valid,
  output logic [7:0]        con_data,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count,
  output logic              err
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [0:DEPTH-1];
  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_ptr;
  logic          r_con_valid;
  logic [7:0]    r_con_data;
  logic          r_err;

  logic          w_run, w_in_mem, w_is_con, w_ld_acc, w_err_set;
  logic [AW-1:0] w_a0, w_a1, w_a2, w_a3;

  assign w_run    = (r_state == RUN);
  assign w_in_mem = (bus_A < 32'(DEPTH));
  assign w_is_con = (bus_A == CON_ADDR);
  assign ld_ready = (r_state == LOAD) && !rst;
  assign w_ld_acc = ld_valid && ld_ready;
  assign cpu_rst  = rst || (r_state == LOAD);

  // Byte lanes wrap inside the memory because AW-bit sums drop the carry.
  assign w_a0 = bus_A[AW-1:0];
  assign w_a1 = w_a0 + AW'(1);
  assign w_a2 = w_a0 + AW'(2);
  assign w_a3 = w_a0 + AW'(3);

  always_comb begin
    w_state_nxt = r_state;
    if ((r_state == LOAD) && w_ld_acc && ld_last) begin
      w_state_nxt = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LOAD;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ld_acc) begin
        r_ptr <= r_ptr + AW'(1);
      end
    end
  end

  always_comb begin
    bus_in = '0;
    if (bus_RE && w_run && w_in_mem) begin
      bus_in = {r_mem[w_a3], r_mem[w_a2], r_mem[w_a1], r_mem[w_a0]};
    end
  end

  // Loader and CPU writes are mutually exclusive by state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_ld_acc) begin
        r_mem[r_ptr] <= ld_data;
      end
      if (w_run && bus_WE && w_in_mem) begin
        r_mem[w_a0] <= bus_out[7:0];
        r_mem[w_a1] <= bus_out[15:8];
        r_mem[w_a2] <= bus_out[23:16];
        r_mem[w_a3] <= bus_out[31:24];
      end
    end
  end

  assign w_err_set = (bus_RE && bus_WE) ||
                     ((bus_RE || bus_WE) && (!w_run || (!w_in_mem && !w_is_con)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_con_valid <= 1'b0;
      r_con_data  <= 8'h00;
      r_err       <= 1'b0;
    end else begin
      r_con_valid <= w_run && bus_WE && w_is_con;
      if (w_run && bus_WE && w_is_con) begin
        r_con_data <= bus_out[7:0];
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign con_valid = r_con_valid;
  assign con_data  = r_con_data;
  assign err       = r_err;

  y86_sat_counter #(.W(CNT_W)) u_rd_cnt (
    .clk (clk),
    .clr (rst),
    .inc (w_run && bus_RE),
    .cnt (rd_count)
  );

  y86_sat_counter #(.W(CNT_W)) u_wr_cnt (
    .clk (clk),
    .clr (rst),
    .inc (w_run && bus_WE),
    .cnt (wr_count)
  );

endmodule

// File: tb/tb_y86_bus_mem.sv
// Bench for y86_bus_mem: per-cycle reference model comparison plus literal checkpoints.
module tb_y86_bus_mem;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] CON   = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        rst, bus_WE, bus_RE, ld_valid, ld_last;
  logic [31:0] bus_A, bus_out;
  logic [7:0]  ld_data;
  logic [31:0] bus_in;
  logic        ld_ready, cpu_rst, con_valid, err;
  logic [7:0]  con_data;
  logic [15:0] rd_count, wr_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  y86_bus_mem #(.DEPTH(DEPTH), .CON_ADDR(CON)) dut (
    .clk(clk), .rst(rst), .bus_A(bus_A), .bus_out(bus_out),
    .bus_WE(bus_WE), .bus_RE(bus_RE), .bus_in(bus_in),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .cpu_rst(cpu_rst), .con_valid(con_valid), .con_data(con_data),
    .rd_count(rd_count), .wr_count(wr_count), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory image with a known-byte map, plus loader/counter/error state.
  logic [7:0] m_mem   [DEPTH];
  bit         m_known [DEPTH];
  bit         m_loading = 1'b1;
  int         m_ptr = 0;
  int         m_rd = 0, m_wr = 0;
  bit         m_err = 1'b0, m_conv = 1'b0;
  logic [7:0] m_cond = 8'h00;

  initial for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;

  always @(posedge clk) begin
    bit in_mem, is_con, eset;
    in_mem = (bus_A < DEPTH);
    is_con = (bus_A == CON);
    if (rst) begin
      m_loading = 1'b1; m_ptr = 0; m_rd = 0; m_wr = 0;
      m_err = 1'b0; m_conv = 1'b0; m_cond = 8'h00;
    end else begin
      eset = (bus_RE && bus_WE) ||
             ((bus_RE || bus_WE) && (m_loading || (!in_mem && !is_con)));
      m_conv = 1'b0;
      if (m_loading) begin
        if (ld_valid) begin
          m_mem[m_ptr] = ld_data;
          m_known[m_ptr] = 1'b1;
          m_ptr = (m_ptr + 1) % DEPTH;
          if (ld_last) m_loading = 1'b0;
        end
      end else begin
        if (bus_RE && m_rd < 65535) m_rd++;
        if (bus_WE && m_wr < 65535) m_wr++;
        if (bus_WE && is_con) begin
          m_conv = 1'b1;
          m_cond = bus_out[7:0];
        end else if (bus_WE && in_mem) begin
          for (int k = 0; k < 4; k++) begin
            m_mem[(bus_A + k) % DEPTH]   = bus_out[8*k +: 8];
            m_known[(bus_A + k) % DEPTH] = 1'b1;
          end
        end
      end
      if (eset) m_err = 1'b1;
    end
  end

  always @(negedge clk) begin
    logic [31:0] exp_in;
    bit known;
    known  = 1'b1;
    exp_in = 32'h0;
    if (bus_RE && !m_loading && bus_A < DEPTH) begin
      for (int k = 0; k < 4; k++) begin
        exp_in[8*k +: 8] = m_mem[(bus_A + k) % DEPTH];
        if (!m_known[(bus_A + k) % DEPTH]) known = 1'b0;
      end
    end
    if (known) chk("bus_in", bus_in, exp_in);
    chk("ld_ready",  {31'b0, ld_ready},  {31'b0, m_loading && !rst});
    chk("cpu_rst",   {31'b0, cpu_rst},   {31'b0, m_loading || rst});
    chk("con_valid", {31'b0, con_valid}, {31'b0, m_conv});
    chk("con_data",  {24'b0, con_data},  {24'b0, m_cond});
    chk("rd_count",  {16'b0, rd_count},  m_rd[31:0]);
    chk("wr_count",  {16'b0, wr_count},  m_wr[31:0]);
    chk("err",       {31'b0, err},       {31'b0, m_err});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_WE = 0; bus_RE = 0; ld_valid = 0; ld_last = 0;
  endtask

  task automatic load(input logic [7:0] d, input bit last);
    ld_valid = 1; ld_data = d; ld_last = last;
    cyc();
    ld_valid = 0; ld_last = 0;
  endtask

  task automatic rd_lit(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus_RE = 1; bus_A = a;
    @(negedge clk);
    chk(name, bus_in, exp);
    cyc();
    bus_RE = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] img [8];
    img = '{8'h8B, 8'h45, 8'h04, 8'h89, 8'hC8, 8'h01, 8'hD8, 8'hF4};
    rst = 1; idle(); bus_A = 0; bus_out = 0; ld_data = 0;
    cyc(); cyc();
    @(negedge clk);
    chk("rst_ld_ready", {31'b0, ld_ready}, 32'd0);
    chk("rst_cpu_rst",  {31'b0, cpu_rst},  32'd1);
    rst = 0;
    cyc();

    // Boot image of 8 bytes; CPU reset releases one cycle after the last byte.
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        @(negedge clk);
        chk("cpu_rst_before_last", {31'b0, cpu_rst}, 32'd1);
      end
      load(img[i], i == 7);
    end
    @(negedge clk);
    chk("cpu_rst_after_last", {31'b0, cpu_rst}, 32'd0);
    rd_lit("read_a1", 32'd1, 32'hC889_0445);

    // Wrap-around write then reads across the top of memory.
    bus_WE = 1; bus_A = 32'd1022; bus_out = 32'h4433_2211;
    cyc(); bus_WE = 0;
    rd_lit("read_wrap", 32'd1022, 32'h4433_2211);
    rd_lit("read_a0",   32'd0,    32'h8904_4433);

    // Console write: one-cycle strobe, memory untouched.
    bus_WE = 1; bus_A = CON; bus_out = 32'h0000_0041;
    cyc(); bus_WE = 0; bus_A = 0;
    @(negedge clk);
    chk("con_valid_pulse", {31'b0, con_valid}, 32'd1);
    chk("con_data",        {24'b0, con_data},  32'h41);
    chk("wr_count_con",    {16'b0, wr_count},  32'd2);
    cyc();
    @(negedge clk);
    chk("con_valid_drop", {31'b0, con_valid}, 32'd0);
    rd_lit("read_a0_after_con", 32'd0, 32'h8904_4433);

    // Out-of-range read: zero data, sticky error.
    @(negedge clk);
    chk("err_before_oor", {31'b0, err}, 32'd0);
    rd_lit("read_oor", 32'h0000_1000, 32'h0);
    @(negedge clk);
    chk("err_oor", {31'b0, err}, 32'd1);
    cyc(); cyc();
    @(negedge clk);
    chk("err_sticky", {31'b0, err}, 32'd1);

    // ld_valid ignored in RUN.
    ld_valid = 1; ld_data = 8'h5A; ld_last = 1;
    cyc(); cyc(); idle();

    // Reset in RUN, partial load, reset mid-load, reload two bytes.
    rst = 1; cyc(); rst = 0;
    @(negedge clk);
    chk("err_cleared", {31'b0, err}, 32'd0);
    load(8'hAA, 0); load(8'hBB, 0); load(8'hCC, 0);
    rst = 1; cyc(); rst = 0;
    load(8'hDD, 0);
    @(negedge clk);
    chk("cpu_rst_reload", {31'b0, cpu_rst}, 32'd1);
    load(8'hEE, 1);
    @(negedge clk);
    chk("cpu_rst_reload_drop", {31'b0, cpu_rst}, 32'd0);
    rd_lit("read_reload", 32'd0, 32'h89CC_EEDD);

    // Simultaneous read and write: read sees old data, write lands, error set.
    bus_RE = 1; bus_WE = 1; bus_A = 32'd4; bus_out = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rw_old_data", bus_in, 32'hF4D8_01C8);
    cyc(); bus_WE = 0; bus_RE = 0;
    @(negedge clk);
    chk("err_rw", {31'b0, err}, 32'd1);
    rd_lit("rw_new_data", 32'd4, 32'hDEAD_BEEF);

    // Bus access during LOAD flags an error.
    rst = 1; cyc(); rst = 0;
    bus_RE = 1; bus_A = 32'd0;
    @(negedge clk);
    chk("read_in_load", bus_in, 32'h0);
    cyc(); bus_RE = 0;
    @(negedge clk);
    chk("err_load_access", {31'b0, err}, 32'd1);
    load(8'h01, 1);

    // Read-count saturation.
    bus_RE = 1; bus_A = 32'd0;
    for (int i = 0; i < 70000; i++) cyc();
    bus_RE = 0;
    @(negedge clk);
    chk("rd_count_sat", {16'b0, rd_count}, 32'h0000_FFFF);
    cyc();
    @(negedge clk);
    chk("rd_count_hold", {16'b0, rd_count}, 32'h0000_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
